// File: rtl/prio_enc_arb_if.sv
// prio_enc_arb_if
// Request/result bundle for the prio_enc_arb arbiter.
//   req_n     : N active-low request lines (producer -> arbiter)
//   rr_mode   : 0 = fixed highest-index priority, 1 = round-robin
//   out_ready : consumer accepts the current result
//   out_valid : arbiter holds an unaccepted winner
//   out_idx   : binary index of the winner
//   code_n    : ~(out_idx+1) while out_valid, otherwise all ones
// Modports: master = requester/consumer side, slave = arbiter side.
interface prio_enc_arb_if #(
  parameter int N = 9,
  parameter int W = 4
);
  logic [N-1:0] req_n;
  logic         rr_mode;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out_idx;
  logic [W-1:0] code_n;

  modport master (
    output req_n,
    output rr_mode,
    output out_ready,
    input  out_valid,
    input  out_idx,
    input  code_n
  );

  modport slave (
    input  req_n,
    input  rr_mode,
    input  out_ready,
    output out_valid,
    output out_idx,
    output code_n
  );
endinterface

// File: rtl/prio_enc_arb.sv
// prio_enc_arb
// Registered active-low priority encoder / arbiter. Picks one winner among
// N active-low requests (fixed highest-index priority or round-robin) and
// holds it under a valid/ready handshake until the consumer accepts it.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : prio_enc_arb_if.slave (req_n, rr_mode, out_ready in;
//           out_valid, out_idx, code_n out -- all outputs registered)
module prio_enc_arb #(
  parameter int N = 9,
  parameter int W = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  prio_enc_arb_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t       state_r;
  state_t       state_nxt_s;
  logic         valid_r;
  logic         valid_nxt_s;
  logic [W-1:0] idx_r;
  logic [W-1:0] idx_nxt_s;
  logic [W-1:0] code_r;
  logic [W-1:0] code_nxt_s;
  logic [W-1:0] ptr_r;
  logic [W-1:0] ptr_nxt_s;
  logic         xfer_s;
  logic [W:0]   arb_s;

  // Search starts at ptr-1 and descends with wrap; ptr=0 (or fixed mode)
  // starts at N-1, which is plain highest-index priority. Returns
  // {found, index}; requests are active-high here.
  function automatic logic [W:0] pick(input logic [N-1:0] req,
                                      input logic [W-1:0] ptr,
                                      input logic         rr);
    int           start;
    int           cand;
    logic [N-1:0] req_sh;
    logic         found;
    logic [W-1:0] idx;
    found = 1'b0;
    idx   = {W{1'b0}};
    if (rr && (ptr != {W{1'b0}})) begin
      start = int'(ptr) - 32'sd1;
    end else begin
      start = N - 32'sd1;
    end
    for (int k = 0; k < N; k++) begin
      cand   = (start >= k) ? (start - k) : (start + N - k);
      req_sh = req >> cand;
      if (!found && req_sh[0]) begin
        found = 1'b1;
        idx   = W'(cand);
      end else begin
        found = found;
      end
    end
    return {found, idx};
  endfunction

  // Active-low "index+1" code.
  function automatic logic [W-1:0] idx_to_code(input logic [W-1:0] idx);
    return ~(idx + {{(W-1){1'b0}}, 1'b1});
  endfunction

  // Pointer update and arbitration; the transfer edge commits the old winner
  // into ptr and the new search already uses that updated ptr.
  always_comb begin
    xfer_s = valid_r & bus.out_ready;
    if (!bus.rr_mode) begin
      ptr_nxt_s = {W{1'b0}};
    end else if (xfer_s) begin
      ptr_nxt_s = idx_r;
    end else begin
      ptr_nxt_s = ptr_r;
    end
    arb_s = pick(~bus.req_n, ptr_nxt_s, bus.rr_mode);
  end

  // Next-state and next-output logic of the IDLE/HOLD machine.
  always_comb begin
    state_nxt_s = state_r;
    valid_nxt_s = valid_r;
    idx_nxt_s   = idx_r;
    code_nxt_s  = code_r;
    case (state_r)
      IDLE: begin
        if (arb_s[W]) begin
          state_nxt_s = HOLD;
          valid_nxt_s = 1'b1;
          idx_nxt_s   = arb_s[W-1:0];
          code_nxt_s  = idx_to_code(arb_s[W-1:0]);
        end else begin
          valid_nxt_s = 1'b0;
          code_nxt_s  = {W{1'b1}};
        end
      end
      HOLD: begin
        if (xfer_s) begin
          if (arb_s[W]) begin
            idx_nxt_s  = arb_s[W-1:0];
            code_nxt_s = idx_to_code(arb_s[W-1:0]);
          end else begin
            state_nxt_s = IDLE;
            valid_nxt_s = 1'b0;
            code_nxt_s  = {W{1'b1}};
          end
        end else begin
          // Held result is frozen regardless of req_n or rr_mode.
          state_nxt_s = HOLD;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        valid_nxt_s = 1'b0;
        idx_nxt_s   = {W{1'b0}};
        code_nxt_s  = {W{1'b1}};
      end
    endcase
  end

  // State, result and pointer registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      valid_r <= 1'b0;
      idx_r   <= {W{1'b0}};
      code_r  <= {W{1'b1}};
      ptr_r   <= {W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      valid_r <= valid_nxt_s;
      idx_r   <= idx_nxt_s;
      code_r  <= code_nxt_s;
      ptr_r   <= ptr_nxt_s;
    end
  end

  assign bus.out_valid = valid_r;
  assign bus.out_idx   = idx_r;
  assign bus.code_n    = code_r;

endmodule

// File: tb/tb_prio_enc_arb.sv
// tb_prio_enc_arb
// Self-checking bench for prio_enc_arb (N=9, W=4): a table of per-cycle
// vectors, hand-written round-robin / mode / reset sequences, and a random
// phase compared against a behavioural model.
module tb_prio_enc_arb;
  localparam int N = 9;
  localparam int W = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  prio_enc_arb_if #(.N(N), .W(W)) bus ();

  prio_enc_arb #(.N(N), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst_n;
    logic [N-1:0] req_n;
    logic         rr;
    logic         ready;
    logic         exp_v;
    logic [W-1:0] exp_idx;
    logic [W-1:0] exp_code;
    logic         chk_idx;
  } vec_t;

  vec_t vecs[16];

  task automatic drive(input logic r, input logic [N-1:0] q, input logic m, input logic rdy);
    rst_n         = r;
    bus.req_n     = q;
    bus.rr_mode   = m;
    bus.out_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic v, input logic [W-1:0] i,
                       input logic [W-1:0] c, input logic chk_idx);
    checks++;
    if (bus.out_valid !== v || (chk_idx && bus.out_idx !== i) || bus.code_n !== c) begin
      failures++;
      $display("FAIL %s: got valid=%0b idx=%0d code=%b, expected valid=%0b idx=%0d code=%b",
               name, bus.out_valid, bus.out_idx, bus.code_n, v, i, c);
    end
  endtask

  // Expected code for a granted index: active-low of index+1.
  function automatic logic [W-1:0] exp_code(input int idx);
    return W'(15 - (idx + 1));
  endfunction

  // Winner = requested index with the largest distance (i - p) mod N,
  // i.e. the first one met when counting down from p-1 with wrap.
  function automatic int ref_win(input logic [N-1:0] req_n, input int p);
    int best;
    int best_key;
    int key;
    best     = -1;
    best_key = -1;
    for (int i = 0; i < N; i++) begin
      if (!req_n[i]) begin
        key = (i - p + N) % N;
        if (key > best_key) begin
          best_key = key;
          best     = i;
        end
      end
    end
    return best;
  endfunction

  task automatic do_reset();
    drive(1'b0, {N{1'b0}}, 1'b0, 1'b1);
    tick();
    tick();
  endtask

  int m_v;
  int m_idx;
  int m_ptr;

  initial begin
    logic [N-1:0] q;
    logic         rr;
    logic         rdy;
    logic         r;
    int           np;
    int           w;
    int           seq_rr[10];
    checks   = 0;
    failures = 0;
    drive(1'b0, {N{1'b0}}, 1'b0, 1'b1);

    // ---------------- table-driven vectors (fixed priority) ----------------
    vecs[0]  = '{1'b0, 9'b000000000, 1'b0, 1'b1, 1'b0, 4'd0, 4'b1111, 1'b1};
    vecs[1]  = '{1'b0, 9'b000000000, 1'b0, 1'b1, 1'b0, 4'd0, 4'b1111, 1'b1};
    vecs[2]  = '{1'b1, 9'b011111111, 1'b0, 1'b1, 1'b1, 4'd8, 4'b0110, 1'b1};
    vecs[3]  = '{1'b1, 9'b111111110, 1'b0, 1'b1, 1'b1, 4'd0, 4'b1110, 1'b1};
    vecs[4]  = '{1'b1, 9'b101011111, 1'b0, 1'b1, 1'b1, 4'd7, 4'b0111, 1'b1};
    vecs[5]  = '{1'b1, 9'b111111111, 1'b0, 1'b1, 1'b0, 4'd0, 4'b1111, 1'b0};
    vecs[6]  = '{1'b1, 9'b111111111, 1'b0, 1'b1, 1'b0, 4'd0, 4'b1111, 1'b0};
    vecs[7]  = '{1'b1, 9'b011111111, 1'b0, 1'b0, 1'b1, 4'd8, 4'b0110, 1'b1};
    vecs[8]  = '{1'b1, 9'b111111110, 1'b0, 1'b0, 1'b1, 4'd8, 4'b0110, 1'b1};
    vecs[9]  = '{1'b1, 9'b011111111, 1'b0, 1'b0, 1'b1, 4'd8, 4'b0110, 1'b1};
    vecs[10] = '{1'b1, 9'b111111110, 1'b0, 1'b0, 1'b1, 4'd8, 4'b0110, 1'b1};
    vecs[11] = '{1'b1, 9'b011111111, 1'b0, 1'b0, 1'b1, 4'd8, 4'b0110, 1'b1};
    vecs[12] = '{1'b1, 9'b111111110, 1'b0, 1'b0, 1'b1, 4'd8, 4'b0110, 1'b1};
    vecs[13] = '{1'b1, 9'b111111110, 1'b0, 1'b1, 1'b1, 4'd0, 4'b1110, 1'b1};
    vecs[14] = '{1'b1, 9'b111111111, 1'b0, 1'b0, 1'b1, 4'd0, 4'b1110, 1'b1};
    vecs[15] = '{1'b1, 9'b111111111, 1'b0, 1'b1, 1'b0, 4'd0, 4'b1111, 1'b0};
    for (int k = 0; k < 16; k++) begin
      drive(vecs[k].rst_n, vecs[k].req_n, vecs[k].rr, vecs[k].ready);
      tick();
      check($sformatf("vec%0d", k), vecs[k].exp_v, vecs[k].exp_idx,
            vecs[k].exp_code, vecs[k].chk_idx);
    end

    // ---------------- round-robin, all requesting ----------------
    do_reset();
    seq_rr = '{8, 7, 6, 5, 4, 3, 2, 1, 0, 8};
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, {N{1'b0}}, 1'b1, 1'b1);
      tick();
      check($sformatf("rr_all%0d", k), 1'b1, W'(seq_rr[k]), exp_code(seq_rr[k]), 1'b1);
    end

    // ---------------- round-robin, bits 5 and 2 ----------------
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 9'b111011011, 1'b1, 1'b1);
      tick();
      w = (k % 2 == 0) ? 5 : 2;
      check($sformatf("rr_52_%0d", k), 1'b1, W'(w), exp_code(w), 1'b1);
    end
    drive(1'b1, 9'b111011011, 1'b1, 1'b1);
    tick();
    check("rr_52_grant5", 1'b1, 4'd5, exp_code(5), 1'b1);
    drive(1'b1, 9'b111011111, 1'b1, 1'b1);
    tick();
    check("rr_drop2", 1'b1, 4'd5, exp_code(5), 1'b1);

    // ---------------- mode switch ----------------
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, {N{1'b0}}, 1'b1, 1'b1);
      tick();
    end
    check("mode_pre", 1'b1, 4'd3, exp_code(3), 1'b1);
    drive(1'b1, {N{1'b0}}, 1'b0, 1'b0);
    tick();
    check("mode_held", 1'b1, 4'd3, exp_code(3), 1'b1);
    drive(1'b1, {N{1'b0}}, 1'b0, 1'b1);
    tick();
    check("mode_fixed", 1'b1, 4'd8, exp_code(8), 1'b1);

    // ---------------- reset mid-HOLD clears ptr ----------------
    do_reset();
    drive(1'b1, {N{1'b0}}, 1'b1, 1'b1);
    tick();
    tick();
    check("rst_pre", 1'b1, 4'd7, exp_code(7), 1'b1);
    drive(1'b1, {N{1'b0}}, 1'b1, 1'b0);
    tick();
    drive(1'b0, {N{1'b0}}, 1'b1, 1'b0);
    tick();
    check("rst_hold", 1'b0, 4'd0, 4'b1111, 1'b1);
    drive(1'b1, {N{1'b0}}, 1'b1, 1'b1);
    tick();
    check("rst_ptr0", 1'b1, 4'd8, exp_code(8), 1'b1);

    // ---------------- random phase against the model ----------------
    do_reset();
    m_v   = 0;
    m_idx = 0;
    m_ptr = 0;
    rr    = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 19) == 0) rr = ~rr;
      r   = ($urandom_range(0, 39) != 0);
      rdy = $urandom_range(0, 1) != 0;
      q   = ($urandom_range(0, 3) == 0) ? {N{1'b1}} : N'($urandom | $urandom);
      drive(r, q, rr, rdy);
      if (!r) begin
        m_v   = 0;
        m_idx = 0;
        m_ptr = 0;
      end else begin
        np = !rr ? 0 : ((m_v != 0 && rdy) ? m_idx : m_ptr);
        if (m_v == 0 || rdy) begin
          w = ref_win(q, rr ? np : 0);
          if (w >= 0) begin
            m_v   = 1;
            m_idx = w;
          end else begin
            m_v = 0;
          end
        end
        m_ptr = np;
      end
      tick();
      check($sformatf("rand%0d", k), m_v != 0, W'(m_idx),
            (m_v != 0) ? exp_code(m_idx) : 4'b1111, (m_v != 0) || !r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
